nn_layer_sequencer: RTL and testbench
=====================================

Name: nn_layer_sequencer

Overview:
- Controller that sequences the shared three-layer fully-connected MAC datapath (784 -> 30 -> 15 -> 10).
- Walks each layer's input index and issues one wide weight-word read per input.
- Aligns MAC enable, first-term (bias load) and index controls to the weight memory read latency.
- Drains the MAC pipe between layers, pulses activation capture, then signals completion to the top-level handshake.

Parameters:
- N_IN, 784, layer-1 input count
- N_H1, 30, layer-1 neuron count = layer-2 input count
- N_H2, 15, layer-2 neuron count = layer-3 input count
- RD_LAT, 1, weight memory read latency in cycles (legal 1..3)
- MAC_LAT, 1, cycles from mac_en until the accumulator result is stable (legal 1..3)
- ADDR_W, 10, weight word address width

Ports:
- Clk, in, 1, clock; single clock domain
- Rst, in, 1, synchronous active-low reset
- start, in, 1, request inference; sampled only in IDLE
- hold, in, 1, stall weight issue (memory not ready)
- busy, out, 1, high from start acceptance through the DONE cycle
- done, out, 1, one-cycle completion pulse
- result_valid, out, 1, level; argmax output is valid
- w_rd, out, 1, weight read strobe
- w_addr, out, ADDR_W, weight word address
- mac_en, out, 1, accumulate enable, aligned to weight data
- mac_first, out, 1, first term of a layer: adder takes bias, not feedback
- mac_layer, out, 2, layer of the current MAC term (1..3)
- mac_idx, out, 10, input index for the current MAC term
- act_latch, out, 1, capture layer activations (one-cycle pulse)
- act_layer, out, 2, layer being captured

Behaviour:
- Reset (Rst=0 at a clock edge): state IDLE, counters 0, delay pipe cleared.
  - All outputs 0, including result_valid.
  - Applies mid-run too; any in-flight terms are discarded.
- States: IDLE, L1, DRAIN1, L2, DRAIN2, L3, DRAIN3, DONE.
- IDLE -> L1 on a clock edge with start=1.
  - That edge sets busy=1, clears result_valid and cnt.
  - start in any other state is ignored.
- Li (issue) states:
  - w_rd = !hold.
  - w_addr = BASE_i + cnt, with BASE_1=0, BASE_2=N_IN, BASE_3=N_IN+N_H1. Default words: 0..783, 784..813, 814..828.
  - cnt increments only when w_rd=1.
  - An issue with cnt == len_i-1 (len = N_IN, N_H1, N_H2) moves to DRAINi and resets cnt to 0.
  - hold=1 keeps w_rd=0 and holds cnt and w_addr.
- Issue-stage tuple {valid=w_rd, first=(cnt==0), layer, idx=cnt} passes through an RD_LAT-deep delay pipe that shifts every cycle regardless of hold.
  - The pipe output drives mac_en, mac_first, mac_layer and mac_idx.
  - Bubbles appear with mac_en=0, and mac_first/mac_layer/mac_idx=0.
- DRAINi states:
  - Last exactly D = RD_LAT + MAC_LAT cycles; w_rd=0; hold ignored.
  - act_latch=1 and act_layer=i in the final DRAIN cycle.
  - Then go to L(i+1); from DRAIN3, go to DONE.
- DONE state lasts one cycle:
  - done=1 and result_valid set (stays 1 until the next accepted start or reset).
  - Next state is IDLE; busy drops in IDLE.
- Latency with no hold: done is asserted N_IN+N_H1+N_H2+3D+1 cycles after the start edge. Default: 836.
- Each hold cycle during an Li state adds exactly one cycle.
- mac_first is asserted exactly once per layer, on that layer's idx=0 term.
- Counters never wrap: cnt width is 10 bits and its maximum is 783.

Decomposition:
- Shared package nn_pkg holds:
  - constants N_IN, N_H1, N_H2, N_OUT, D_BASE1/2/3, total word count 829;
  - enum seq_state_e;
  - 2-bit layer encoding (1, 2, 3).
- Sub-module nn_delay_pipe: parameterised WIDTH/DEPTH shift register with synchronous active-low clear, used for the issue-to-MAC alignment.

Test Plan:
- Defaults, start pulse, no hold:
  - w_addr runs 0..783, 784..813, 814..828 with w_rd gaps of 2 cycles at each layer boundary.
  - done exactly 836 cycles after the start edge; busy high for 836 cycles.
- Defaults: each mac_first coincides with mac_en, mac_idx=0 and mac_layer 1/2/3, at 1 cycle after the w_addr 0/784/814 issue.
  - act_latch is seen 3 times with act_layer 1, 2, 3.
- hold high for 5 cycles at cnt=100 in L1:
  - w_addr holds at 100; 5 mac_en bubbles appear; done arrives at cycle 841.
  - mac_idx sequence is unbroken except for the bubbles.
- Rst low at cycle 400 of a run:
  - Next cycle all outputs are 0 and state is IDLE.
  - A new start then gives a clean 836-cycle run with result_valid=0 until done.
- start held high through the whole run: only one run occurs; a new run begins on the cycle after DONE (IDLE with start=1).
- RD_LAT=3, MAC_LAT=2:
  - mac_en lags w_rd by 3 cycles.
  - DRAIN states last 5 cycles.
  - done arrives 829+15+1 = 845 cycles after start.

Source files
------------

// File: rtl/nn_layer_sequencer_pkg.sv
// nn_pkg: shared constants, state encoding and MAC-term
// bundle for the three-layer MAC sequencer.
package nn_pkg;
   localparam int N_IN    = 784;
   localparam int N_H1    = 30;
   localparam int N_H2    = 15;
   localparam int N_OUT   = 10;
   localparam int D_BASE1 = 0;
   localparam int D_BASE2 = N_IN;
   localparam int D_BASE3 = N_IN + N_H1;
   localparam int N_WORDS = N_IN + N_H1 + N_H2;
   localparam int IDX_W   = 10;

   // Issue and drain states alternate so "next" is state+1.
   typedef enum logic [2:0] {
      S_IDLE,
      S_L1,
      S_DRAIN1,
      S_L2,
      S_DRAIN2,
      S_L3,
      S_DRAIN3,
      S_DONE
   } seq_state_e;

   typedef logic [1:0] layer_t;
   localparam layer_t LAYER_NONE = 2'd0;
   localparam layer_t LAYER1     = 2'd1;
   localparam layer_t LAYER2     = 2'd2;
   localparam layer_t LAYER3     = 2'd3;

   typedef struct packed {
      logic             valid;
      logic             first;
      layer_t           layer;
      logic [IDX_W-1:0] idx;
   } mac_term_t;

   function automatic layer_t state_layer(seq_state_e s);
      layer_t l;
      unique case (s)
         S_L1, S_DRAIN1: l = LAYER1;
         S_L2, S_DRAIN2: l = LAYER2;
         S_L3, S_DRAIN3: l = LAYER3;
         default:        l = LAYER_NONE;
      endcase
      return l;
   endfunction
endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Handshake, weight-read and MAC-control bundle between the
// sequencer (master) and the datapath/top level (slave).
interface nn_layer_sequencer_if #(
   parameter int ADDR_W = 10
);
   import nn_pkg::*;

   logic              start;
   logic              hold;
   logic              busy;
   logic              done;
   logic              result_valid;
   logic              w_rd;
   logic [ADDR_W-1:0] w_addr;
   logic              mac_en;
   logic              mac_first;
   layer_t            mac_layer;
   logic [IDX_W-1:0]  mac_idx;
   logic              act_latch;
   layer_t            act_layer;

   modport master (
      input  start, hold,
      output busy, done, result_valid,
      output w_rd, w_addr,
      output mac_en, mac_first, mac_layer, mac_idx,
      output act_latch, act_layer
   );

   modport slave (
      output start, hold,
      input  busy, done, result_valid,
      input  w_rd, w_addr,
      input  mac_en, mac_first, mac_layer, mac_idx,
      input  act_latch, act_layer
   );
endinterface

// File: rtl/nn_layer_sequencer_delay_pipe.sv
// Fixed-depth shift register with synchronous active-low clear;
// aligns issue-stage controls to weight-memory read data.
module nn_delay_pipe #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk_i,
   input  logic             clr_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] pipe_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (!clr_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/nn_layer_sequencer.sv
// Sequencer for the shared 784->30->15->10 MAC datapath:
// issues weight reads, aligns MAC controls, drains and latches.
module nn_layer_sequencer #(
   parameter int N_IN    = nn_pkg::N_IN,
   parameter int N_H1    = nn_pkg::N_H1,
   parameter int N_H2    = nn_pkg::N_H2,
   parameter int RD_LAT  = 1,
   parameter int MAC_LAT = 1,
   parameter int ADDR_W  = 10
) (
   input logic                  Clk,
   input logic                  Rst,
   nn_layer_sequencer_if.master bus
);
   import nn_pkg::*;

   localparam int D = RD_LAT + MAC_LAT;
   localparam logic [IDX_W-1:0] D_LAST = IDX_W'(D - 1);

   seq_state_e        state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              rv_q, rv_d;
   layer_t            layer;
   logic [ADDR_W-1:0] base;
   logic [IDX_W-1:0]  last;
   logic              issuing;
   logic              rd;
   mac_term_t         issue, mac;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rv_q    <= rv_d;
      end
   end

   assign layer   = state_layer(state_q);
   assign issuing = state_q inside {S_L1, S_L2, S_L3};

   always_comb begin
      base = '0;
      last = '0;
      unique case (layer)
         LAYER1: last = IDX_W'(N_IN - 1);
         LAYER2: begin
            base = ADDR_W'(N_IN);
            last = IDX_W'(N_H1 - 1);
         end
         LAYER3: begin
            base = ADDR_W'(N_IN + N_H1);
            last = IDX_W'(N_H2 - 1);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rv_d          = rv_q;
      rd            = 1'b0;
      bus.act_latch = 1'b0;
      bus.act_layer = LAYER_NONE;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_L1;
               cnt_d   = '0;
               rv_d    = 1'b0;
            end
         end
         S_L1, S_L2, S_L3: begin
            rd = !bus.hold;
            if (rd && cnt_q == last) begin
               cnt_d   = '0;
               state_d = seq_state_e'(state_q + 3'd1);
            end else if (rd) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DRAIN1, S_DRAIN2, S_DRAIN3: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == D_LAST) begin
               cnt_d         = '0;
               bus.act_latch = 1'b1;
               bus.act_layer = layer;
               state_d       = seq_state_e'(state_q + 3'd1);
            end
         end
         S_DONE: begin
            rv_d    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bubbles carry all-zero controls, not just valid=0.
   assign issue = '{
      valid: rd,
      first: rd && (cnt_q == '0),
      layer: rd ? layer : LAYER_NONE,
      idx:   rd ? cnt_q : '0
   };

   nn_delay_pipe #(
      .WIDTH($bits(mac_term_t)),
      .DEPTH(RD_LAT)
   ) u_pipe (
      .clk_i (Clk),
      .clr_ni(Rst),
      .d_i   (issue),
      .q_o   (mac)
   );

   assign bus.busy         = (state_q != S_IDLE);
   assign bus.done         = (state_q == S_DONE);
   assign bus.result_valid = rv_q | bus.done;
   assign bus.w_rd         = rd;
   assign bus.w_addr       = issuing ? base + ADDR_W'(cnt_q) : '0;
   assign bus.mac_en       = mac.valid;
   assign bus.mac_first    = mac.first;
   assign bus.mac_layer    = mac.layer;
   assign bus.mac_idx      = mac.idx;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench: table of full runs (hold patterns, two latency
// configs) plus hand sequences for held start and mid-run reset.
module tb_nn_layer_sequencer;
   import nn_pkg::*;

   typedef struct packed {
      int sel;
      int rd_lat;
      int hs;
      int hl;
      int hold_addr;
      int exp_done;
   } vec_t;

   typedef struct packed {
      int done_cyc;
      int busy;
      int rd;
      int mac;
      int first;
      int latch;
      int last_latch;
      int addr_err;
      int align_err;
      int mac_err;
      int latch_err;
      int hold_err;
      int rv_err;
      int post_busy;
      int post_rv;
   } stat_t;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       rv;
      logic       w_rd;
      logic [9:0] w_addr;
      logic       mac_en;
      logic       mac_first;
      logic [1:0] mac_layer;
      logic [9:0] mac_idx;
      logic       act_latch;
      logic [1:0] act_layer;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic hold;
   logic sel;
   obs_t oa, ob, o;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   nn_layer_sequencer_if #(.ADDR_W(10)) ifa ();
   nn_layer_sequencer_if #(.ADDR_W(10)) ifb ();

   assign ifa.start = start & ~sel;
   assign ifb.start = start & sel;
   assign ifa.hold  = hold;
   assign ifb.hold  = hold;

   nn_layer_sequencer dut_a (
      .Clk(clk),
      .Rst(rst),
      .bus(ifa)
   );

   nn_layer_sequencer #(
      .RD_LAT (3),
      .MAC_LAT(2)
   ) dut_b (
      .Clk(clk),
      .Rst(rst),
      .bus(ifb)
   );

   assign oa = {ifa.busy, ifa.done, ifa.result_valid, ifa.w_rd,
                ifa.w_addr, ifa.mac_en, ifa.mac_first, ifa.mac_layer,
                ifa.mac_idx, ifa.act_latch, ifa.act_layer};
   assign ob = {ifb.busy, ifb.done, ifb.result_valid, ifb.w_rd,
                ifb.w_addr, ifb.mac_en, ifb.mac_first, ifb.mac_layer,
                ifb.mac_idx, ifb.act_latch, ifb.act_layer};
   assign o  = sel ? ob : oa;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic run(input vec_t v, output stat_t s);
      int cyc;
      int ea;
      int el;
      int ei;
      int len [5];
      bit hist [2048];
      bit hw;
      len = '{0, 784, 30, 15, 0};
      s = '0;
      s.done_cyc = -1;
      sel = v.sel[0];
      hold = 1'b0;
      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      ea = 0;
      el = 1;
      ei = 0;
      while (s.done_cyc < 0 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         hold = (cyc >= v.hs && cyc < v.hs + v.hl);
         #1;
         if (o.busy) s.busy++;
         if (hold) begin
            if (o.w_rd) s.hold_err++;
            if (v.hold_addr >= 0 && o.w_addr != v.hold_addr)
               s.hold_err++;
         end
         if (o.w_rd) begin
            s.rd++;
            if (o.w_addr != 10'(ea)) s.addr_err++;
            ea++;
         end
         hist[cyc] = o.w_rd;
         hw = (cyc > v.rd_lat) ? hist[cyc - v.rd_lat] : 1'b0;
         if (o.mac_en != hw) s.align_err++;
         if (o.mac_en) begin
            s.mac++;
            if (o.mac_first) s.first++;
            if (o.mac_layer != el || o.mac_idx != ei ||
                o.mac_first != (ei == 0))
               s.mac_err++;
            ei++;
            if (el < 4 && ei == len[el]) begin
               el++;
               ei = 0;
            end
         end else if (o.mac_first || o.mac_layer != 0 || o.mac_idx != 0) begin
            s.mac_err++;
         end
         if (o.act_latch) begin
            s.latch++;
            s.last_latch = cyc;
            if (o.act_layer != s.latch) s.latch_err++;
         end
         if (o.done) begin
            s.done_cyc = cyc;
            if (!o.rv) s.rv_err++;
         end else if (o.rv) begin
            s.rv_err++;
         end
      end
      hold = 1'b0;
      @(negedge clk);
      #1;
      s.post_busy = o.busy;
      s.post_rv = o.rv;
   endtask

   task automatic chk_row(input int r, input vec_t v, input stat_t s);
      string p;
      p = $sformatf("row%0d", r);
      chk({p, " done_cyc"}, s.done_cyc, v.exp_done);
      chk({p, " busy_cycles"}, s.busy, v.exp_done);
      chk({p, " w_rd_count"}, s.rd, 829);
      chk({p, " mac_en_count"}, s.mac, 829);
      chk({p, " mac_first_count"}, s.first, 3);
      chk({p, " act_latch_count"}, s.latch, 3);
      chk({p, " last_latch_cyc"}, s.last_latch, v.exp_done - 1);
      chk({p, " w_addr_seq_err"}, s.addr_err, 0);
      chk({p, " mac_align_err"}, s.align_err, 0);
      chk({p, " mac_term_err"}, s.mac_err, 0);
      chk({p, " act_layer_err"}, s.latch_err, 0);
      chk({p, " hold_err"}, s.hold_err, 0);
      chk({p, " result_valid_err"}, s.rv_err, 0);
      chk({p, " idle_busy"}, s.post_busy, 0);
      chk({p, " idle_result_valid"}, s.post_rv, 1);
   endtask

   initial begin
      vec_t  vt [5];
      stat_t st;
      int    dn;
      int    dc;
      int    bz;
      int    b837;
      int    b838;
      int    a838;

      vt[0] = '{0, 1, 0, 0, -1, 836};
      vt[1] = '{0, 1, 101, 5, 100, 841};
      vt[2] = '{0, 1, 785, 2, -1, 836};
      vt[3] = '{0, 1, 792, 3, 789, 839};
      vt[4] = '{1, 3, 0, 0, -1, 845};

      rst = 1'b0;
      start = 1'b0;
      hold = 1'b0;
      sel = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset outputs a", int'(oa), 0);
      chk("reset outputs b", int'(ob), 0);
      rst = 1'b1;

      for (int i = 0; i < 5; i++) begin
         run(vt[i], st);
         chk_row(i, vt[i], st);
      end

      sel = 1'b0;
      @(negedge clk);
      start = 1'b1;
      dn = 0;
      dc = -1;
      bz = 0;
      b837 = -1;
      b838 = -1;
      a838 = -1;
      for (int c = 1; c <= 838; c++) begin
         @(negedge clk);
         #1;
         if (c <= 836 && o.busy) bz++;
         if (c <= 836 && o.done) begin
            dn++;
            dc = c;
         end
         if (c == 837) b837 = o.busy;
         if (c == 838) begin
            b838 = o.busy;
            a838 = int'(o.w_rd && o.w_addr == 10'd0);
         end
      end
      chk("held start done_cyc", dc, 836);
      chk("held start done_count", dn, 1);
      chk("held start busy_cycles", bz, 836);
      chk("held start idle_busy", b837, 0);
      chk("held start restart_busy", b838, 1);
      chk("held start restart_issue", a838, 1);
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1;
      chk("pre reset busy", o.busy, 1);
      chk("pre reset mac_en", o.mac_en, 1);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("mid reset outputs", int'(o), 0);
      chk("mid reset result_valid", o.rv, 0);
      rst = 1'b1;
      run(vt[0], st);
      chk_row(5, vt[0], st);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
